// File: rtl/aes_round_key_gen.sv
// aes_round_key_gen: on-the-fly AES-128/256 key expander, one round key per next_key
module aes_sbox (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, m;
    p = 8'h00;
    m = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ m;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // Inverse as x^254 = product of x^(2^k) for k=1..7; zero maps to zero naturally
  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  for (genvar g = 0; g < 4; g++) begin : g_byte
    assign word_o[8*g +: 8] = sub_byte(word_i[8*g +: 8]);
  end
endmodule

module aes_round_key_gen (
  input  logic         clk,
  input  logic         reset,
  input  logic         keylen,
  input  logic [255:0] key,
  input  logic         init_key,
  input  logic         next_key,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         last_key
);
  typedef enum logic [1:0] {EMPTY, RUN, DONE} st_t;
  st_t st_q, st_d;
  logic [127:0] a_q, a_d, b_q, b_d, rk_q, rk_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         phase_q, phase_d, mode_q, mode_d, last_q, last_d;
  logic [3:0]   emitted_q, emitted_d, idx_q, idx_d, nr;
  logic [31:0]  s, sb_in, sb_out, t, n0, n1, n2, n3;
  logic         emit;
  aes_sbox u_sbox (.word_i(sb_in), .word_o(sb_out));
  always_comb begin
    nr = mode_q ? 4'd14 : 4'd10;
    s = mode_q ? b_q[31:0] : a_q[31:0];
    sb_in = phase_q ? s : {s[23:0], s[31:24]};
    t = sb_out ^ (phase_q ? 32'h0 : {rcon_q, 24'h0});
    n0 = a_q[127:96] ^ t;
    n1 = a_q[95:64] ^ n0;
    n2 = a_q[63:32] ^ n1;
    n3 = a_q[31:0] ^ n2;
    emit = (st_q == RUN) && next_key && !init_key;
    st_d = st_q;
    a_d = a_q;
    b_d = b_q;
    rcon_d = rcon_q;
    phase_d = phase_q;
    mode_d = mode_q;
    emitted_d = emitted_q;
    rk_d = rk_q;
    idx_d = idx_q;
    last_d = last_q;
    if (init_key) begin
      st_d = RUN;
      a_d = key[255:128];
      b_d = key[127:0];
      rcon_d = 8'h01;
      phase_d = 1'b0;
      mode_d = keylen;
      emitted_d = 4'd0;
    end else if (emit) begin
      rk_d = a_q;
      idx_d = emitted_q;
      last_d = emitted_q == nr;
      emitted_d = emitted_q + 4'd1;
      st_d = (emitted_q == nr) ? DONE : RUN;
      rcon_d = phase_q ? rcon_q : ({rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00));
      a_d = mode_q ? b_q : {n0, n1, n2, n3};
      b_d = mode_q ? {n0, n1, n2, n3} : b_q;
      phase_d = mode_q ? !phase_q : 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= EMPTY;
      a_q <= '0;
      b_q <= '0;
      rcon_q <= 8'h01;
      phase_q <= 1'b0;
      mode_q <= 1'b0;
      emitted_q <= 4'd0;
      rk_q <= '0;
      idx_q <= 4'd0;
      last_q <= 1'b0;
    end else begin
      st_q <= st_d;
      a_q <= a_d;
      b_q <= b_d;
      rcon_q <= rcon_d;
      phase_q <= phase_d;
      mode_q <= mode_d;
      emitted_q <= emitted_d;
      rk_q <= rk_d;
      idx_q <= idx_d;
      last_q <= last_d;
    end
  end
  assign round_key = rk_q;
  assign round_idx = idx_q;
  assign last_key = last_q;
endmodule
